clk_divider_prog: RTL
=====================

// Module: clk_divider_prog
// PURPOSE
//   Programmable divide-by-N counter producing a one-cycle tick, a divided square wave
//   and the live count. Successor to the fixed mod-10 counter: adds synchronous reset,
//   enable, clear, a runtime-loadable divisor applied glitch-free at period boundaries,
//   and illegal-divisor rejection. Feeds clock-enables and slow strobes in the clk domain.
// PARAMETERS
//   WIDTH        4   counter/divisor width; divisor range 2..2^WIDTH-1
//   DEFAULT_DIV  10  divisor in effect after reset; must be 2..2^WIDTH-1
// PORTS
//   clk        in   1      single clock; all logic on posedge clk
//   rst        in   1      synchronous, active-high reset
//   en         in   1      count enable
//   clear      in   1      restart current period at 0; divisor and pending kept
//   div_in     in   WIDTH  new divisor value
//   div_load   in   1      1-cycle strobe: capture div_in as pending divisor
//   count_out  out  WIDTH  current count, 0..D-1 (D = divisor in effect)
//   tick       out  1      1-cycle pulse on each wrap to 0
//   div_out    out  1      divided output, period D cycles of enabled count
//   div_cur    out  WIDTH  divisor currently in effect (D)
//   pend_valid out  1      a pending divisor waits for the next wrap
//   load_err   out  1      1-cycle pulse: div_load with div_in < 2, load ignored
// BEHAVIOUR
//   All outputs registered. Reset: count_out=0, tick=0, div_out=0, div_cur=DEFAULT_DIV,
//     pend_valid=0, load_err=0, pending register=DEFAULT_DIV.
//   Priority per cycle: rst > clear > en. rst overrides everything, incl. div_load.
//   Counting (en=1, clear=0): count_out==D-1 -> count_out<=0 (wrap), else count_out+1.
//   tick=1 exactly in the cycle count_out shows 0 after a wrap; never after rst/clear.
//   en=0: count_out, div_out held; tick=0. div_load still processed.
//   clear=1: count_out<=0, div_out<=0, tick<=0; div_cur, pending, pend_valid unchanged.
//   div_out invariant: div_out == (count_out >= ceil(D/2)); high floor(D/2) cycles/period
//     (D=10: 5 high/5 low; D=5: 2 high/3 low; D=2: 1/1). Updated with count, no glitches.
//   div_load with div_in>=2: pending<=div_in, pend_valid<=1 (newest overwrites older).
//   div_load with div_in<2: load_err=1 next cycle, pending and pend_valid unchanged.
//   Divisor switch only at wrap: on the wrap cycle, if pend_valid (or a legal div_load
//     in that same cycle, which wins) -> div_cur<=new value, pend_valid<=0. New period
//     starts at count 0 with new D; div_out computed against new D.
//   Load and wrap same cycle: the loaded value takes effect at that wrap.
//   No mid-period change of D; count_out never exceeds D-1.
//   Mid-operation rst: all state to reset values next edge; pending discarded.
// TESTING
//   rst 1 cycle, en=1 40 cycles, DEFAULT_DIV=10 -> count 0..9 repeats; tick at cycles
//     10,20,30; div_out high counts 5..9.
//   en toggled low for 3 cycles at count 4 -> count_out/div_out hold at 4/0; no tick;
//     wrap delayed by 3 cycles.
//   div_in=5 div_load at count 2 -> pend_valid=1; D stays 10 until wrap; then
//     div_cur=5, periods of 5, div_out 2 high/3 low, pend_valid=0.
//   div_load div_in=1 then div_in=0 -> load_err pulses each, div_cur/pend_valid unchanged.
//   Loads 7 then 3 within one period -> only 3 applied at wrap; div_load=6 exactly in
//     the wrap cycle -> next period D=6.
//   clear at count 7 -> count 0, div_out 0, no tick; rst at count 3 with pending=4 ->
//     count 0, div_cur=10, pend_valid=0.

Source files
------------

// File: rtl/clk_divider_prog.sv
// Programmable divide-by-N counter: one-cycle wrap tick, divided square wave, live count.
// Divisor reloads take effect only at a period boundary; divisors below 2 are rejected.
module clk_divider_prog #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] count_out,
  output logic             tick,
  output logic             div_out,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend_valid,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] half_up;
  logic [WIDTH-1:0] count_inc;
  logic             wrap;
  logic             legal_load;
  logic             bad_load;

  // half_up = ceil(D/2): div_out is high for counts at or above this threshold.
  always_comb begin
    half_up    = (div_cur >> 1) + {{(WIDTH-1){1'b0}}, div_cur[0]};
    count_inc  = count_out + ONE;
    wrap       = (count_out == (div_cur - ONE));
    legal_load = div_load && (div_in >= TWO);
    bad_load   = div_load && (div_in < TWO);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out  <= '0;
      tick       <= 1'b0;
      div_out    <= 1'b0;
      div_cur    <= DEF_DIV;
      pend       <= DEF_DIV;
      pend_valid <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_err <= bad_load;
      if (legal_load) begin
        pend       <= div_in;
        pend_valid <= 1'b1;
      end

      if (clear) begin
        count_out <= '0;
        div_out   <= 1'b0;
        tick      <= 1'b0;
      end else if (en) begin
        if (wrap) begin
          count_out <= '0;
          div_out   <= 1'b0;
          tick      <= 1'b1;
          // A load arriving on the wrap cycle beats an older pending value.
          if (legal_load) begin
            div_cur    <= div_in;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            div_cur    <= pend;
            pend_valid <= 1'b0;
          end
        end else begin
          count_out <= count_inc;
          div_out   <= (count_inc >= half_up);
          tick      <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule
